audio_playback_ctrl: RTL
========================

AUDIO_PLAYBACK_CTRL -- requirements
Module: audio_playback_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 16, giving the per-channel sample width in bits.
REQ-002 The block SHALL have parameter NUM_FRAMES, default 320, giving the number of stereo frames per song; legal range 1..65535.
REQ-003 The block SHALL have parameter LOOP, default 0; 1 restarts the song after the last frame instead of finishing.
REQ-004 The block SHALL derive CNT_W = $clog2(NUM_FRAMES+1) and use it for every frame-count signal.
REQ-005 The block SHALL have port CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1, synchronous active-low reset (0 = reset).
REQ-007 The block SHALL have ports START (in, 1, one-cycle start/restart pulse), STOP (in, 1, abort pulse) and PAUSE (in, 1, level, hold playback).
REQ-008 The block SHALL have ports SRC_REQ (out, 1), SRC_VALID (in, 1), SRC_LDATA (in, SAMPLE_W) and SRC_RDATA (in, SAMPLE_W), forming the sample-source handshake.
REQ-009 The block SHALL have ports CODEC_INIT (out, 1), CODEC_INIT_FINISH (in, 1) and CODEC_DATA_OVER (in, 1), forming the codec-interface handshake.
REQ-010 The block SHALL have ports LDATA (out, SAMPLE_W) and RDATA (out, SAMPLE_W), the registered samples presented to the codec.
REQ-011 The block SHALL have ports FRAME_CNT (out, CNT_W, frames completed), BUSY (out, 1) and MUS_DONE (out, 1).

Function
REQ-012 The FSM SHALL use states INIT, INIT_WAIT, IDLE, FETCH, PLAY, ADVANCE, HOLD and DONE.
REQ-013 INIT SHALL last 1 cycle with CODEC_INIT=1, then go to INIT_WAIT; INIT_WAIT SHALL go to IDLE on the first cycle CODEC_INIT_FINISH=1.
REQ-014 IDLE with START=1 SHALL go to FETCH and clear FRAME_CNT to 0.
REQ-015 FETCH SHALL drive SRC_REQ=1 (combinational, state-decoded) until SRC_VALID=1; on that cycle SRC_LDATA/SRC_RDATA SHALL be captured into LDATA/RDATA (visible the next cycle) and the FSM SHALL go to PLAY.
REQ-016 PLAY SHALL wait for CODEC_DATA_OVER=1, then go to ADVANCE; CODEC_DATA_OVER outside PLAY SHALL be ignored.
REQ-017 ADVANCE SHALL last 1 cycle, increment FRAME_CNT, and select the next state:
 - new count == NUM_FRAMES, LOOP=0: DONE;
 - new count == NUM_FRAMES, LOOP=1: FRAME_CNT<=0, FETCH;
 - otherwise with PAUSE=1: HOLD;
 - otherwise: FETCH.
REQ-018 HOLD SHALL stay while PAUSE=1 and go to FETCH on the first cycle PAUSE=0; LDATA/RDATA SHALL hold their last values.
REQ-019 DONE SHALL drive MUS_DONE=1 and hold FRAME_CNT=NUM_FRAMES; START in DONE SHALL clear FRAME_CNT and go to FETCH.
REQ-020 STOP=1 in FETCH, PLAY, ADVANCE, HOLD or DONE SHALL go to IDLE next cycle with FRAME_CNT=0; STOP SHALL override START, SRC_VALID and CODEC_DATA_OVER in the same cycle (no capture, no increment).
REQ-021 STOP and START SHALL be ignored in INIT and INIT_WAIT; START SHALL be ignored in FETCH, PLAY, ADVANCE and HOLD.
REQ-022 BUSY SHALL be 1 in FETCH, PLAY, ADVANCE and HOLD, and 0 otherwise.
REQ-023 FRAME_CNT SHALL never exceed NUM_FRAMES, with no wrap through 2^CNT_W.

Reset
REQ-024 While RESET=0 at a clock edge, the state SHALL become INIT and LDATA=0, RDATA=0, FRAME_CNT=0, MUS_DONE=0, BUSY=0, SRC_REQ=0.
REQ-025 CODEC_INIT SHALL be 0 during reset and 1 in the first cycle after RESET returns to 1.
REQ-026 Reset asserted mid-playback SHALL abandon the frame, discard any pending SRC_VALID, and re-run codec initialisation.

Configuration
REQ-027 With macro AUDIO_VOLUME_SHIFT_EN defined, the block SHALL add port VOL_SHIFT (in, 3), and captured samples SHALL be arithmetically right-shifted (signed) by VOL_SHIFT, sampled on the capture cycle.
REQ-028 Without AUDIO_VOLUME_SHIFT_EN, VOL_SHIFT SHALL be absent and samples SHALL pass unmodified.

Verification
REQ-029 Reset then CODEC_INIT_FINISH pulse 3 cycles after the INIT cycle -> CODEC_INIT high exactly 1 cycle, FSM reaches IDLE, BUSY=0.
REQ-030 NUM_FRAMES=4, LOOP=0, START, source returns 0x1234/0xABCD, codec DATA_OVER per frame -> LDATA=0x1234 and RDATA=0xABCD one cycle after SRC_VALID, 4 fetches, FRAME_CNT=4, MUS_DONE=1.
REQ-031 NUM_FRAMES=3, LOOP=1 -> after frame 3, FRAME_CNT returns to 0 and SRC_REQ reasserts; MUS_DONE stays 0.
REQ-032 PAUSE held 10 cycles across ADVANCE of frame 1 -> HOLD 10 cycles, SRC_REQ=0, then FETCH for frame 2 with FRAME_CNT=1.
REQ-033 STOP in the same cycle as CODEC_DATA_OVER in PLAY at FRAME_CNT=2 -> IDLE next cycle, FRAME_CNT=0, no increment.
REQ-034 With AUDIO_VOLUME_SHIFT_EN defined, VOL_SHIFT=2 and SRC_LDATA=0x8000 -> LDATA=0xE000.

Source files
------------

// File: rtl/audio_playback_ctrl.sv
// -----------------------------------------------------------------------------
// audio_playback_ctrl
//
// Sequences stereo audio playback. It brings up the codec once after reset,
// then on START fetches one stereo frame at a time from a sample source,
// presents it to the codec on LDATA/RDATA, and waits for the codec to finish
// consuming it. It counts completed frames and either finishes or loops at the
// end of the song.
//
// Optional feature (macro AUDIO_VOLUME_SHIFT_EN):
//   Adds input VOL_SHIFT[2:0]. Captured samples are arithmetically right
//   shifted (signed) by VOL_SHIFT, sampled on the capture cycle. Without the
//   macro, samples pass through unmodified and VOL_SHIFT does not exist.
//
// Parameters:
//   SAMPLE_W    per-channel sample width in bits
//   NUM_FRAMES  stereo frames per song (1..65535)
//   LOOP        1 = restart after the last frame, 0 = finish
//
// Ports:
//   CLK                single clock, rising edge
//   RESET              synchronous, active low
//   START/STOP         one-cycle start/restart and abort pulses
//   PAUSE              level; holds playback between frames
//   SRC_REQ/SRC_VALID  sample-source handshake, SRC_LDATA/SRC_RDATA data
//   CODEC_INIT         codec bring-up pulse; CODEC_INIT_FINISH acknowledges
//   CODEC_DATA_OVER    codec has consumed the current frame
//   LDATA/RDATA        registered samples presented to the codec
//   FRAME_CNT          frames completed, BUSY, MUS_DONE status
// -----------------------------------------------------------------------------
module audio_playback_ctrl #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_FRAMES = 320,
  parameter int LOOP       = 0,
  localparam int CNT_W     = $clog2(NUM_FRAMES + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                STOP,
  input  logic                PAUSE,
  output logic                SRC_REQ,
  input  logic                SRC_VALID,
  input  logic [SAMPLE_W-1:0] SRC_LDATA,
  input  logic [SAMPLE_W-1:0] SRC_RDATA,
  output logic                CODEC_INIT,
  input  logic                CODEC_INIT_FINISH,
  input  logic                CODEC_DATA_OVER,
`ifdef AUDIO_VOLUME_SHIFT_EN
  input  logic [2:0]          VOL_SHIFT,
`endif
  output logic [SAMPLE_W-1:0] LDATA,
  output logic [SAMPLE_W-1:0] RDATA,
  output logic [CNT_W-1:0]    FRAME_CNT,
  output logic                BUSY,
  output logic                MUS_DONE
);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_IDLE      = 3'd2,
    ST_FETCH     = 3'd3,
    ST_PLAY      = 3'd4,
    ST_ADVANCE   = 3'd5,
    ST_HOLD      = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FRAMES);

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0] ldata_q, ldata_d;
  logic [SAMPLE_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [2:0]          vol_shift_s;

`ifdef AUDIO_VOLUME_SHIFT_EN
  assign vol_shift_s = VOL_SHIFT;

  // Signed attenuation: sign bit is replicated into the vacated MSBs.
  function automatic logic [SAMPLE_W-1:0] scale_sample(
    input logic [SAMPLE_W-1:0] smp,
    input logic [2:0]          sh
  );
    return SAMPLE_W'($signed(smp) >>> sh);
  endfunction
`else
  assign vol_shift_s = 3'd0;

  function automatic logic [SAMPLE_W-1:0] scale_sample(
    input logic [SAMPLE_W-1:0] smp,
    input logic [2:0]          sh
  );
    logic unused_sh;
    unused_sh = ^sh;
    return smp;
  endfunction
`endif

  // The counter only advances from below LAST_CNT, so this never wraps.
  assign cnt_inc_s = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state, frame counter and sample-capture logic.
  always_comb begin
    state_d     = state_q;
    armed_d     = 1'b1;
    frame_cnt_d = frame_cnt_q;
    ldata_d     = ldata_q;
    rdata_d     = rdata_q;
    case (state_q)
      // armed_q is 0 only on the cycle right after reset, so INIT is
      // held for exactly one cycle with RESET high before moving on.
      ST_INIT: begin
        if (armed_q) state_d = ST_INIT_WAIT;
        else         state_d = ST_INIT;
      end
      ST_INIT_WAIT: begin
        if (CODEC_INIT_FINISH) state_d = ST_IDLE;
        else                   state_d = ST_INIT_WAIT;
      end
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_FETCH;
          frame_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // STOP wins over SRC_VALID: no capture when aborting.
      ST_FETCH: begin
        if (STOP) begin
          state_d     = ST_IDLE;
          frame_cnt_d = '0;
        end else if (SRC_VALID) begin
          state_d = ST_PLAY;
          ldata_d = scale_sample(SRC_LDATA, vol_shift_s);
          rdata_d = scale_sample(SRC_RDATA, vol_shift_s);
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_PLAY: begin
        if (STOP) begin
          state_d     = ST_IDLE;
          frame_cnt_d = '0;
        end else if (CODEC_DATA_OVER) begin
          state_d = ST_ADVANCE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      // End of song takes priority over PAUSE.
      ST_ADVANCE: begin
        if (STOP) begin
          state_d     = ST_IDLE;
          frame_cnt_d = '0;
        end else if (cnt_inc_s == LAST_CNT) begin
          if (LOOP != 0) begin
            state_d     = ST_FETCH;
            frame_cnt_d = '0;
          end else begin
            state_d     = ST_DONE;
            frame_cnt_d = cnt_inc_s;
          end
        end else begin
          frame_cnt_d = cnt_inc_s;
          if (PAUSE) state_d = ST_HOLD;
          else       state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (STOP) begin
          state_d     = ST_IDLE;
          frame_cnt_d = '0;
        end else if (PAUSE) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (STOP) begin
          state_d     = ST_IDLE;
          frame_cnt_d = '0;
        end else if (START) begin
          state_d     = ST_FETCH;
          frame_cnt_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_INIT;
        frame_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_INIT;
      armed_q     <= 1'b0;
      frame_cnt_q <= '0;
      ldata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      frame_cnt_q <= frame_cnt_d;
      ldata_q     <= ldata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Status outputs decoded from registered state only.
  assign SRC_REQ    = (state_q == ST_FETCH);
  assign CODEC_INIT = (state_q == ST_INIT) && armed_q;
  assign BUSY       = (state_q == ST_FETCH) || (state_q == ST_PLAY) ||
                      (state_q == ST_ADVANCE) || (state_q == ST_HOLD);
  assign MUS_DONE   = (state_q == ST_DONE);
  assign FRAME_CNT  = frame_cnt_q;
  assign LDATA      = ldata_q;
  assign RDATA      = rdata_q;

endmodule
